// File: rtl/cpu_test_sequencer.sv
// cpu_test_sequencer: programmable vector engine that drives the multi-cycle cpu and checks its output.
// Build option: define SEQ_STOP_ON_FAIL_EN to end a run at the first output mismatch.
module cpu_test_sequencer #(
  parameter int W       = 16,
  parameter int DEPTH   = 8,
  parameter int AW      = $clog2(DEPTH),
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   n_vec,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [W-1:0]  prog_instr,
  input  logic [W-1:0]  prog_expect,
  input  logic          prog_chk,
  output logic [W-1:0]  cpu_in,
  output logic          cpu_load,
  output logic          cpu_s,
  input  logic [W-1:0]  cpu_out,
  input  logic          cpu_w,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [AW:0]   err_count,
  output logic [AW-1:0] fail_idx
);

`ifdef SEQ_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   DEPTH_N  = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, CHECK, DONE} state_t;
  state_t state, state_nxt;

  logic [W-1:0]     instr_mem  [DEPTH];
  logic [W-1:0]     expect_mem [DEPTH];
  logic [DEPTH-1:0] chk_mem;

  logic [AW:0]   n_r;
  logic [AW-1:0] idx;
  logic [AW-1:0] ld_idx;
  logic [TW-1:0] timer;
  logic [AW:0]   n_clamp;
  logic [W-1:0]  ld_instr;
  logic          idle_like, go, w_ok, tmo_hit, last, mism, no_fault;

  function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign idle_like = (state == IDLE) || (state == DONE);
  assign go        = idle_like && start;
  assign n_clamp   = (n_vec > DEPTH_N) ? DEPTH_N : n_vec;
  // the first WAIT cycle (timer still 0) ignores w while the cpu leaves its idle state
  assign w_ok      = (state == WAIT) && (timer != '0) && cpu_w;
  assign tmo_hit   = (state == WAIT) && !w_ok && (timer == TMR_LAST);
  assign last      = ({1'b0, idx} == n_r - 1'b1);
  assign mism      = chk_mem[idx] && (cpu_out != expect_mem[idx]);
  assign no_fault  = (err_count == '0) && !timeout;
  assign ld_idx    = (state == CHECK) ? idx + 1'b1 : '0;
  // a write landing on the start edge must reach the first LOAD
  assign ld_instr  = (prog_we && idle_like && prog_addr == ld_idx) ? prog_instr : instr_mem[ld_idx];
  assign pass      = done && (err_count == '0) && !timeout;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (n_clamp == '0) ? DONE : LOAD;
      LOAD:       state_nxt = ISSUE;
      ISSUE:      state_nxt = WAIT;
      WAIT: begin
        if (w_ok)         state_nxt = CHECK;
        else if (tmo_hit) state_nxt = DONE;
      end
      CHECK: begin
        if (last || (STOP_ON_FAIL && mism)) state_nxt = DONE;
        else                                state_nxt = LOAD;
      end
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (prog_we && idle_like) begin
      instr_mem[prog_addr]  <= prog_instr;
      expect_mem[prog_addr] <= prog_expect;
      chk_mem[prog_addr]    <= prog_chk;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_in    <= '0;
      cpu_load  <= 1'b0;
      cpu_s     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      err_count <= '0;
      fail_idx  <= '0;
      idx       <= '0;
      timer     <= '0;
      n_r       <= '0;
    end else begin
      cpu_load <= (state_nxt == LOAD);
      cpu_s    <= (state_nxt == ISSUE);
      busy     <= (state_nxt == LOAD) || (state_nxt == ISSUE) ||
                  (state_nxt == WAIT) || (state_nxt == CHECK);
      done     <= (state_nxt == DONE);
      if (go) begin
        n_r       <= n_clamp;
        idx       <= '0;
        err_count <= '0;
        timeout   <= 1'b0;
        fail_idx  <= '0;
      end
      if (state_nxt == LOAD) cpu_in <= ld_instr;
      if (state == ISSUE) timer <= '0;
      if (state == WAIT)  timer <= timer + 1'b1;
      if (tmo_hit) begin
        timeout <= 1'b1;
        if (no_fault) fail_idx <= idx;
      end
      if (state == CHECK) begin
        if (mism) begin
          err_count <= sat_inc(err_count);
          if (no_fault) fail_idx <= idx;
        end
        if (state_nxt == LOAD) idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// Bench for cpu_test_sequencer: stub cpu plus a vector-level reference model of each run.
module tb_cpu_test_sequencer;
  localparam int W = 16, DEPTH = 8, AW = 3, TMO = 64;
`ifdef SEQ_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, prog_we = 1'b0, prog_chk = 1'b0;
  logic [AW:0]   n_vec = '0;
  logic [AW-1:0] prog_addr = '0;
  logic [W-1:0]  prog_instr = '0, prog_expect = '0;
  logic [W-1:0]  cpu_in, cpu_out = '0;
  logic          cpu_load, cpu_s, cpu_w = 1'b1, busy, done, pass, timeout;
  logic [AW:0]   err_count;
  logic [AW-1:0] fail_idx;

  cpu_test_sequencer #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .n_vec(n_vec),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_instr(prog_instr),
    .prog_expect(prog_expect), .prog_chk(prog_chk),
    .cpu_in(cpu_in), .cpu_load(cpu_load), .cpu_s(cpu_s),
    .cpu_out(cpu_out), .cpu_w(cpu_w),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .fail_idx(fail_idx)
  );

  always #5 clk = ~clk;

  logic [W-1:0] m_instr [DEPTH], m_expect [DEPTH], resp [DEPTH];
  logic         m_chk [DEPTH];
  int           rise [DEPTH];
  bit           hang [DEPTH];

  int n_chk = 0, n_fail = 0;
  int cyc_now = 0, s_cnt = 0, base = 0, both_hi = 0, cnt = 0, t0 = 0;
  bit hang_now = 1'b0;
  logic [W-1:0] ld_q [$];
  int e_err, e_fidx, e_cyc, e_iss;
  bit e_tmo;

  always @(posedge clk) cyc_now++;

  // stub cpu: w drops the cycle after s and rises rise[v] cycles after s (never if hang)
  always @(posedge clk) begin : stub
    int v;
    if (cpu_load && cpu_s) both_hi <= both_hi + 1;
    if (cpu_load) ld_q.push_back(cpu_in);
    if (cpu_s) begin
      v = (s_cnt - base) & 7;
      cpu_w    <= 1'b0;
      cpu_out  <= resp[v];
      cnt      <= rise[v] - 2;
      hang_now <= hang[v];
      s_cnt    <= s_cnt + 1;
    end else if (!cpu_w && !hang_now) begin
      if (cnt == 0) cpu_w <= 1'b1;
      else          cnt <= cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic prog(input int a, input logic [W-1:0] ins, input logic [W-1:0] ex, input logic c);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a[AW-1:0]; prog_instr = ins; prog_expect = ex; prog_chk = c;
    if (!busy) begin
      m_instr[a] = ins; m_expect[a] = ex; m_chk[a] = c;
    end
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  // reference: walk the vectors, summing cycles per vector and accumulating faults
  task automatic model(input int nreq);
    int n;
    n = (nreq > DEPTH) ? DEPTH : nreq;
    e_err = 0; e_fidx = 0; e_tmo = 1'b0; e_cyc = 0; e_iss = 0;
    for (int i = 0; i < n; i++) begin
      e_iss++;
      if (hang[i]) begin
        e_cyc += 2 + TMO;
        e_tmo = 1'b1;
        if (e_err == 0) e_fidx = i;
        break;
      end
      e_cyc += 3 + rise[i];
      if (m_chk[i] && resp[i] != m_expect[i]) begin
        if (e_err == 0) e_fidx = i;
        if (e_err < 15) e_err++;
        if (STOP) break;
      end
    end
  endtask

  task automatic start_run(input int n, input bit we, input int a, input logic [W-1:0] ins,
                           input logic [W-1:0] ex, input logic c);
    @(negedge clk);
    if (we) begin
      prog_we = 1'b1; prog_addr = a[AW-1:0]; prog_instr = ins; prog_expect = ex; prog_chk = c;
      m_instr[a] = ins; m_expect[a] = ex; m_chk[a] = c;
    end
    start = 1'b1; n_vec = n[AW:0]; base = s_cnt; ld_q.delete();
    model(n);
    @(posedge clk); #1;
    start = 1'b0; prog_we = 1'b0; t0 = cyc_now;
  endtask

  task automatic finish_run(input string tag);
    while (!done && (cyc_now - t0) < 400) begin
      @(posedge clk); #1;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_cycles"}, cyc_now - t0, e_cyc);
    check({tag, "_err"}, err_count, e_err);
    check({tag, "_fidx"}, fail_idx, e_fidx);
    check({tag, "_tmo"}, timeout, e_tmo);
    check({tag, "_pass"}, pass, (e_err == 0) && !e_tmo);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_issues"}, s_cnt - base, e_iss);
    check({tag, "_loads"}, ld_q.size(), e_iss);
    for (int i = 0; i < ld_q.size() && i < DEPTH; i++)
      check({tag, "_instr"}, ld_q[i], m_instr[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_instr[i] = '0; m_expect[i] = '0; m_chk[i] = 1'b0;
      resp[i] = '0; rise[i] = 3; hang[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);   check("rst_done", done, 0);
    check("rst_pass", pass, 0);   check("rst_tmo", timeout, 0);
    check("rst_err", err_count, 0); check("rst_fidx", fail_idx, 0);
    check("rst_load", cpu_load, 0); check("rst_s", cpu_s, 0);
    check("rst_in", cpu_in, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", busy, 0); check("idle_done", done, 0);

    prog(0, 16'hD003, 16'h0003, 1'b1);
    prog(1, 16'hD102, 16'h0002, 1'b1);
    prog(2, 16'hA061, 16'h0005, 1'b1);
    for (int i = 0; i < 3; i++) resp[i] = m_expect[i];
    start_run(3, 0, 0, '0, '0, 1'b0);
    finish_run("match");
    check("match_18", cyc_now - t0, 18);

    resp[1] = 16'h0004;
    start_run(3, 0, 0, '0, '0, 1'b0);
    finish_run("mism");

    resp[1] = m_expect[1];
    hang[0] = 1'b1;
    start_run(3, 0, 0, '0, '0, 1'b0);
    finish_run("tmo");
    hang[0] = 1'b0;

    for (int i = 0; i < DEPTH; i++) rise[i] = 6;
    start_run(3, 0, 0, '0, '0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("wait_busy", busy, 1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("rstw_s", cpu_s, 0);    check("rstw_busy", busy, 0);
    check("rstw_done", done, 0);  check("rstw_load", cpu_load, 0);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) rise[i] = 3;
    start_run(3, 0, 0, '0, '0, 1'b0);
    finish_run("rerun");

    start_run(0, 0, 0, '0, '0, 1'b0);
    check("n0_done1", done, 1);
    check("n0_pass1", pass, 1);
    finish_run("n0");

    for (int a = 3; a < DEPTH; a++) prog(a, W'($urandom), W'($urandom), 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      resp[i] = m_expect[i]; rise[i] = 2 + $urandom % 4;
    end
    start_run(15, 0, 0, '0, '0, 1'b0);
    prog(0, 16'hFFFF, 16'hFFFF, 1'b1);
    finish_run("n15");
    start_run(1, 0, 0, '0, '0, 1'b0);
    finish_run("busywr");

    resp[0] = 16'h0042;
    start_run(1, 1, 0, 16'h1234, 16'h0042, 1'b1);
    finish_run("samecyc");

    for (int it = 0; it < 16; it++) begin
      for (int a = 0; a < DEPTH; a++) prog(a, W'($urandom), W'($urandom), ($urandom % 4) != 0);
      for (int i = 0; i < DEPTH; i++) begin
        rise[i] = 2 + $urandom % 5;
        hang[i] = ($urandom % 12) == 0;
        resp[i] = (($urandom % 3) == 0) ? W'($urandom) : m_expect[i];
      end
      start_run($urandom % 16, 0, 0, '0, '0, 1'b0);
      finish_run("rand");
    end

    check("load_s_overlap", both_hi, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
